// File: rtl/pht_counter_table_if.sv
// Predictor-side bus of the pattern history table.
//   master : fetch predictor / branch-resolution trainer
//   slave  : pht_counter_table
//   Read group : ren, raddr -> rdata (one cycle later)
//   Train      : upd_valid/upd_ready handshake with upd_index, upd_taken
//   Status     : init_busy (init sweep running)
interface pht_counter_table_if #(
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned GROUP_BITS  = 1,
    parameter int unsigned INDEX_WIDTH = 13
);
    localparam int unsigned LANES = 2 ** GROUP_BITS;
    localparam int unsigned RDW   = LANES * CTR_BITS;

    logic                              ren;
    logic [INDEX_WIDTH-GROUP_BITS-1:0] raddr;
    logic [RDW-1:0]                    rdata;
    logic                              upd_valid;
    logic                              upd_ready;
    logic [INDEX_WIDTH-1:0]            upd_index;
    logic                              upd_taken;
    logic                              init_busy;

    modport master (
        output ren, raddr, upd_valid, upd_index, upd_taken,
        input  rdata, upd_ready, init_busy
    );

    modport slave (
        input  ren, raddr, upd_valid, upd_index, upd_taken,
        output rdata, upd_ready, init_busy
    );
endinterface

// File: rtl/pht_counter_table.sv
// Branch pattern history table of 2**INDEX_WIDTH saturating counters.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : grouped read port (latency 1, write-first bypass),
//                    two-stage read-modify-write train port, init_busy status
// After reset a sweep writes INIT_VALUE to every counter, one per cycle;
// trains are refused until the sweep completes.
module pht_counter_table #(
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned GROUP_BITS  = 1,
    parameter int unsigned INDEX_WIDTH = 13,
    parameter int unsigned INIT_VALUE  = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    pht_counter_table_if.slave   bus
);
    localparam int unsigned LANES = 2 ** GROUP_BITS;
    localparam int unsigned DEPTH = 2 ** INDEX_WIDTH;
    localparam int unsigned RDW   = LANES * CTR_BITS;

    localparam logic [CTR_BITS-1:0]    CTR_INIT = CTR_BITS'(INIT_VALUE);
    localparam logic [CTR_BITS-1:0]    CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [INDEX_WIDTH-1:0] PTR_LAST = {INDEX_WIDTH{1'b1}};

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] init_ptr_q;
    logic                   busy_q;
    logic                   ready_q;
    logic [RDW-1:0]         rdata_q;

    logic [CTR_BITS-1:0]    mem [DEPTH];

    // S1 stage of the train pipeline
    logic                   s1_valid_q;
    logic [INDEX_WIDTH-1:0] s1_index_q;
    logic                   s1_taken_q;
    logic [CTR_BITS-1:0]    s1_old_q;

    logic                   accept_c;
    logic [CTR_BITS-1:0]    s1_new_c;
    logic [CTR_BITS-1:0]    s0_old_c;
    logic [RDW-1:0]         rd_group_c;
    logic [INDEX_WIDTH-1:0] lane_idx_c;

    assign accept_c = bus.upd_valid & ready_q;

    // Next-state logic: sweep ends once the last counter has been written
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (init_ptr_q == PTR_LAST) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    // Saturating update, then S0 operand with forwarding from S1
    always_comb begin
        s1_new_c = s1_old_q;
        if (s1_taken_q) begin
            if (s1_old_q != CTR_MAX) s1_new_c = s1_old_q + CTR_BITS'(1);
        end else begin
            if (s1_old_q != '0) s1_new_c = s1_old_q - CTR_BITS'(1);
        end
        s0_old_c = mem[bus.upd_index];
        if (s1_valid_q && (s1_index_q == bus.upd_index)) s0_old_c = s1_new_c;
    end

    // Group read with write-first bypass of the counter S1 writes this cycle
    always_comb begin
        rd_group_c = '0;
        lane_idx_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_idx_c = (INDEX_WIDTH'(bus.raddr) << GROUP_BITS) | INDEX_WIDTH'(i);
            if (state_q == ST_INIT)
                rd_group_c[i*CTR_BITS +: CTR_BITS] = CTR_INIT;
            else if (s1_valid_q && (s1_index_q == lane_idx_c))
                rd_group_c[i*CTR_BITS +: CTR_BITS] = s1_new_c;
            else
                rd_group_c[i*CTR_BITS +: CTR_BITS] = mem[lane_idx_c];
        end
    end

    // Control state, status outputs, read data and train pipeline
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_index_q <= '0;
            s1_taken_q <= 1'b0;
            s1_old_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_INIT);
            ready_q <= (state_d == ST_READY);
            if (state_q == ST_INIT) init_ptr_q <= init_ptr_q + INDEX_WIDTH'(1);
            if (bus.ren) rdata_q <= rd_group_c;
            s1_valid_q <= accept_c;
            if (accept_c) begin
                s1_index_q <= bus.upd_index;
                s1_taken_q <= bus.upd_taken;
                s1_old_q   <= s0_old_c;
            end
        end
    end

    // Counter array; the sweep and S1 never write in the same cycle
    always_ff @(posedge clock) begin
        if (state_q == ST_INIT)
            mem[init_ptr_q] <= CTR_INIT;
        else if (s1_valid_q)
            mem[s1_index_q] <= s1_new_c;
    end

    assign bus.rdata     = rdata_q;
    assign bus.init_busy = busy_q;
    assign bus.upd_ready = ready_q;

endmodule

// File: tb/tb_pht_counter_table.sv
// Bench for pht_counter_table: 16-counter table, 2-bit counters, 2-lane groups.
// Stimulus pushes expected read groups into a queue; a monitor pops and compares.
module tb_pht_counter_table;
    localparam int unsigned CB    = 2;
    localparam int unsigned GB    = 1;
    localparam int unsigned IW    = 4;
    localparam int unsigned IV    = 1;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LANES = 2;
    localparam int unsigned RDW   = 4;
    localparam int unsigned CMAX  = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    pht_counter_table_if #(.CTR_BITS(CB), .GROUP_BITS(GB), .INDEX_WIDTH(IW)) bus ();

    pht_counter_table #(
        .CTR_BITS(CB), .GROUP_BITS(GB), .INDEX_WIDTH(IW), .INIT_VALUE(IV)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int model [DEPTH];
    int since_rel = 0;
    logic [RDW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: reads see every train accepted at an earlier edge, in order
    function automatic logic [RDW-1:0] model_group(input int ra, input bit busy);
        logic [RDW-1:0] g;
        g = '0;
        for (int i = 0; i < int'(LANES); i++)
            g[i*CB +: CB] = busy ? 2'(IV) : 2'(model[ra*LANES + i]);
        return g;
    endfunction

    // Called at a negedge: checks status, drives one cycle, updates model
    task automatic step(input logic r, input int ra, input logic uv, input int ui, input logic ut);
        bit busy;
        busy = (since_rel < int'(DEPTH));
        check("init_busy", 32'(bus.init_busy), 32'(busy));
        check("upd_ready", 32'(bus.upd_ready), 32'(!busy));
        bus.ren       = r;
        bus.raddr     = 3'(ra);
        bus.upd_valid = uv;
        bus.upd_index = 4'(ui);
        bus.upd_taken = ut;
        if (r) exp_q.push_back(model_group(ra, busy));
        if (uv && !busy) begin
            if (ut) model[ui] = (model[ui] == int'(CMAX)) ? model[ui] : model[ui] + 1;
            else    model[ui] = (model[ui] == 0) ? 0 : model[ui] - 1;
        end
        since_rel++;
        @(negedge clock);
    endtask

    // Asynchronous reset mid-cycle, held for a few cycles, released on a negedge
    task automatic pulse_reset(input int hold);
        #2;
        reset_n       = 1'b0;
        bus.ren       = 1'b0;
        bus.upd_valid = 1'b0;
        #1;
        check("rst_rdata", 32'(bus.rdata), 32'h0);
        check("rst_busy", 32'(bus.init_busy), 32'h1);
        check("rst_ready", 32'(bus.upd_ready), 32'h0);
        check("rst_queue", 32'(exp_q.size()), 32'h0);
        repeat (hold) @(negedge clock);
        reset_n = 1'b1;
        since_rel = 0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = int'(IV);
    endtask

    // Monitor: a read accepted at a posedge is compared at the next negedge
    initial begin
        logic fire;
        logic [RDW-1:0] e;
        forever begin
            @(posedge clock);
            fire = bus.ren && reset_n;
            @(negedge clock);
            if (fire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rdata_unexpected actual=%0h expected=none", bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", 32'(bus.rdata), 32'(e));
                end
            end
        end
    end

    initial begin
        int busy_cycles;
        bus.ren = 1'b0; bus.raddr = '0; bus.upd_valid = 1'b0;
        bus.upd_index = '0; bus.upd_taken = 1'b0;

        // Sweep with reads on every group; trains offered during init are ignored
        @(negedge clock);
        pulse_reset(2);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.init_busy) busy_cycles++;
            step(1'b1, i % 8, 1'($urandom_range(0, 1)), 5, 1'b1);
        end
        check("busy_cycles", 32'(busy_cycles), 32'd16);

        // Saturation on counter 5
        repeat (4) step(1'b0, 0, 1'b1, 5, 1'b1);
        step(1'b1, 2, 1'b0, 0, 1'b0);
        repeat (5) step(1'b0, 0, 1'b1, 5, 1'b0);
        step(1'b1, 2, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1, 5, 1'b1);
        step(1'b1, 2, 1'b0, 0, 1'b0);

        // Bypass: read group 3 while S1 writes counter 7
        step(1'b0, 0, 1'b1, 7, 1'b1);
        step(1'b1, 3, 1'b0, 0, 1'b0);
        step(1'b1, 3, 1'b0, 0, 1'b0);

        // Back-to-back trains to counter 6, then read
        step(1'b0, 0, 1'b1, 6, 1'b1);
        step(1'b0, 0, 1'b1, 6, 1'b1);
        step(1'b0, 0, 1'b1, 6, 1'b0);
        step(1'b1, 3, 1'b0, 0, 1'b0);

        // Randomised traffic concentrated on a few counters to hit hazards
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), int'($urandom_range(4, 11)),
                 1'($urandom_range(0, 1)));

        // Reset at sweep cycle 9, then full re-init and read everything
        pulse_reset(2);
        for (int i = 0; i < 9; i++) step(1'b1, i % 8, 1'b0, 0, 1'b0);
        pulse_reset(1);
        for (int i = 0; i < 16; i++) step(1'b1, i % 8, 1'b1, 3, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, i, 1'b0, 0, 1'b0);

        // Reset while a train of counter 2 sits in S1
        step(1'b0, 0, 1'b1, 2, 1'b1);
        step(1'b0, 0, 1'b1, 2, 1'b1);
        pulse_reset(1);
        for (int i = 0; i < 17; i++) step(1'b0, 0, 1'b1, 2, 1'b1);
        step(1'b1, 1, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0, 0, 1'b0);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
